rvm_lsu: RTL and testbench

//  Parametrised load/store unit between rvm_control and the core memory port.

---
 rtl/rvm_lsu_pkg.sv | 18 +
 rtl/rvm_lsu_align.sv | 33 +++
 rtl/rvm_lsu.sv | 110 +++++++++++
 tb/tb_rvm_lsu.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/rvm_lsu_pkg.sv
// rvm_lsu_pkg: size/cause codes, FSM state encodings and alignment helper for the load/store unit.
package rvm_lsu_pkg;
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;
    localparam logic [1:0] CAUSE_OK       = 2'd0;
    localparam logic [1:0] CAUSE_MISALIGN = 2'd1;
    localparam logic [1:0] CAUSE_BUS_ERR  = 2'd2;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'd3;
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;
    // A double is never legal on a 32-bit datapath, whatever its address.
    function automatic logic misaligned(input logic [2:0] a, input logic [1:0] sz, input logic is32);
        return (sz == SZ_H && a[0]) || (sz == SZ_W && a[1:0] != 2'd0) || (sz == SZ_D && (is32 || a != 3'd0));
    endfunction
endpackage

// File: rtl/rvm_lsu_align.sv
// rvm_lsu_align: lane enables, store-data replication and load extract/extend.
module rvm_lsu_align
    import rvm_lsu_pkg::*;
#(
    parameter int XLEN = 32,
    localparam int NB = XLEN / 8,
    localparam int LW = $clog2(NB)
) (
    input  logic [1:0]      i_size,
    input  logic            i_signed,
    input  logic [LW-1:0]   i_lane,
    input  logic [XLEN-1:0] i_wdata,
    input  logic [XLEN-1:0] i_rdata,
    output logic [NB-1:0]   o_b_en,
    output logic [XLEN-1:0] o_wdata,
    output logic [XLEN-1:0] o_rdata
);
    logic [7:0]      w_mask8;
    logic [XLEN-1:0] w_sh;
    logic [XLEN-1:0] w_msk;
    logic            w_sbit;

    assign w_mask8 = i_size == SZ_B ? 8'h01 : i_size == SZ_H ? 8'h03 : i_size == SZ_W ? 8'h0F : 8'hFF;
    assign o_b_en  = NB'(w_mask8) << i_lane;
    assign o_wdata = i_size == SZ_B ? {NB{i_wdata[7:0]}} :
                     i_size == SZ_H ? {(NB/2){i_wdata[15:0]}} :
                     i_size == SZ_W ? {(NB/4){i_wdata[31:0]}} : i_wdata;
    assign w_sh    = i_rdata >> {i_lane, 3'b000};
    assign w_msk   = i_size == SZ_D ? '1 : (XLEN'(1) << (7'd8 << i_size)) - XLEN'(1);
    // Sign bit is the top bit of the size mask.
    assign w_sbit  = i_signed && i_size != SZ_D && |(w_sh & w_msk & ~(w_msk >> 1));
    assign o_rdata = (w_sh & w_msk) | (w_sbit ? ~w_msk : '0);
endmodule

// File: rtl/rvm_lsu.sv
// rvm_lsu: single-outstanding load/store unit with stall hold, timeout abort and cause reporting.
module rvm_lsu
    import rvm_lsu_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int ADDR_W    = 32,
    parameter int MAX_STALL = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [1:0]          req_size,
    input  logic                req_signed,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [XLEN-1:0]     req_wdata,
    output logic                rsp_valid,
    output logic [XLEN-1:0]     rsp_rdata,
    output logic [1:0]          rsp_cause,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic [XLEN-1:0]     mem_rdata,
    output logic [XLEN-1:0]     mem_wdata,
    output logic                mem_c_en,
    output logic [XLEN/8-1:0]   mem_b_en,
    input  logic                mem_error,
    input  logic                mem_stall
);
    localparam int NB = XLEN / 8;
    localparam int LW = $clog2(NB);
    localparam int CW = MAX_STALL > 0 ? $clog2(MAX_STALL + 1) : 1;

    logic [1:0]        r_state;
    logic              r_write;
    logic [1:0]        r_size;
    logic              r_signed;
    logic [ADDR_W-1:0] r_addr;
    logic [XLEN-1:0]   r_wdata;
    logic [CW-1:0]     r_cnt;
    logic [XLEN-1:0]   r_rdata;
    logic [1:0]        r_cause;
    logic [NB-1:0]     w_b_en;
    logic [XLEN-1:0]   w_wdata;
    logic [XLEN-1:0]   w_rdata;
    logic              w_mis;
    logic              w_timeout;

    rvm_lsu_align #(.XLEN(XLEN)) u_align (
        .i_size  (r_size),
        .i_signed(r_signed),
        .i_lane  (r_addr[LW-1:0]),
        .i_wdata (r_wdata),
        .i_rdata (mem_rdata),
        .o_b_en  (w_b_en),
        .o_wdata (w_wdata),
        .o_rdata (w_rdata)
    );

    assign req_ready = r_state == ST_IDLE;
    assign rsp_valid = r_state == ST_RESP;
    assign rsp_rdata = r_rdata;
    assign rsp_cause = r_cause;
    assign mem_c_en  = r_state == ST_ACCESS;
    assign mem_b_en  = mem_c_en && r_write ? w_b_en : '0;
    assign mem_addr  = {r_addr[ADDR_W-1:LW], {LW{1'b0}}};
    assign mem_wdata = w_wdata;
    assign w_mis     = misaligned(req_addr[2:0], req_size, XLEN == 32);
    assign w_timeout = MAX_STALL > 0 && r_cnt == CW'(MAX_STALL);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_write  <= 1'b0;
            r_size   <= SZ_B;
            r_signed <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_cnt    <= '0;
            r_rdata  <= '0;
            r_cause  <= CAUSE_OK;
        end else if (r_state == ST_IDLE) begin
            if (req_valid) begin
                r_write  <= req_write;
                r_size   <= req_size;
                r_signed <= req_signed;
                r_addr   <= req_addr;
                r_wdata  <= req_wdata;
                r_cnt    <= '0;
                r_rdata  <= '0;
                r_cause  <= w_mis ? CAUSE_MISALIGN : CAUSE_OK;
                r_state  <= w_mis ? ST_RESP : ST_ACCESS;
            end
        end else if (r_state == ST_ACCESS) begin
            if (!mem_stall) begin
                r_state <= ST_RESP;
                r_cause <= mem_error ? CAUSE_BUS_ERR : CAUSE_OK;
                r_rdata <= mem_error || r_write ? '0 : w_rdata;
            end else if (w_timeout) begin
                r_state <= ST_RESP;
                r_cause <= CAUSE_TIMEOUT;
                r_rdata <= '0;
            end else begin
                r_cnt <= &r_cnt ? r_cnt : r_cnt + CW'(1);
            end
        end else begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end
    end
endmodule

// File: tb/tb_rvm_lsu.sv
// tb_rvm_lsu: directed checks of a 32-bit and a 64-bit rvm_lsu sharing one request stream.
module tb_rvm_lsu;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic [63:0] mem_rdata = '0;
    logic        mem_error = 1'b0;
    logic        mem_stall = 1'b0;
    logic        a_ready, a_rvalid, a_cen;
    logic [31:0] a_rdata, a_maddr, a_mwdata;
    logic [1:0]  a_cause;
    logic [3:0]  a_ben;
    logic        b_ready, b_rvalid, b_cen;
    logic [63:0] b_rdata, b_mwdata;
    logic [31:0] b_maddr;
    logic [1:0]  b_cause;
    logic [7:0]  b_ben;
    int vec = 0;
    int errs = 0;

    always #5 clk = ~clk;

    rvm_lsu #(.XLEN(32), .ADDR_W(32), .MAX_STALL(16)) u32 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(a_ready),
        .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata[31:0]), .rsp_valid(a_rvalid),
        .rsp_rdata(a_rdata), .rsp_cause(a_cause), .mem_addr(a_maddr),
        .mem_rdata(mem_rdata[31:0]), .mem_wdata(a_mwdata), .mem_c_en(a_cen),
        .mem_b_en(a_ben), .mem_error(mem_error), .mem_stall(mem_stall)
    );

    rvm_lsu #(.XLEN(64), .ADDR_W(32), .MAX_STALL(16)) u64 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(b_ready),
        .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(b_rvalid),
        .rsp_rdata(b_rdata), .rsp_cause(b_cause), .mem_addr(b_maddr),
        .mem_rdata(mem_rdata), .mem_wdata(b_mwdata), .mem_c_en(b_cen),
        .mem_b_en(b_ben), .mem_error(mem_error), .mem_stall(mem_stall)
    );

    // Presents one request for a single accept edge; returns just after that edge.
    task automatic drive(input logic w, input logic [1:0] s, input logic sg,
                         input logic [31:0] a, input logic [63:0] d);
        @(negedge clk);
        req_write = w; req_size = s; req_signed = sg; req_addr = a; req_wdata = d;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        vec++; if (a_ready !== 1'b1) begin errs++; $display("FAIL rst_ready: got %b want 1", a_ready); end
        vec++; if ({a_rvalid, a_cen, a_ben} !== 6'd0) begin errs++; $display("FAIL rst_ctl: got %b want 0", {a_rvalid, a_cen, a_ben}); end
        vec++; if ({a_maddr, a_mwdata, a_rdata, a_cause} !== 98'd0) begin errs++; $display("FAIL rst_data: got %h want 0", {a_maddr, a_mwdata, a_rdata, a_cause}); end
        reset = 1'b0;
    endtask

    task automatic test_load_byte;
        mem_rdata = 64'h0000_0000_80AA_BBCC;
        drive(1'b0, 2'd0, 1'b1, 32'h103, 64'h0);
        @(negedge clk);
        vec++; if (a_cen !== 1'b1) begin errs++; $display("FAIL lb_cen: got %b want 1", a_cen); end
        vec++; if (a_maddr !== 32'h100) begin errs++; $display("FAIL lb_addr: got %h want 100", a_maddr); end
        vec++; if (a_ben !== 4'b0000) begin errs++; $display("FAIL lb_ben: got %b want 0000", a_ben); end
        vec++; if (a_rvalid !== 1'b0) begin errs++; $display("FAIL lb_early: got %b want 0", a_rvalid); end
        @(negedge clk);
        vec++; if (a_rvalid !== 1'b1) begin errs++; $display("FAIL lb_rvalid: got %b want 1", a_rvalid); end
        vec++; if (a_rdata !== 32'hFFFF_FF80) begin errs++; $display("FAIL lb_rdata: got %h want ffffff80", a_rdata); end
        vec++; if (a_cause !== 2'd0) begin errs++; $display("FAIL lb_cause: got %0d want 0", a_cause); end
        @(negedge clk);
        vec++; if ({a_rvalid, a_ready} !== 2'b01) begin errs++; $display("FAIL lb_pulse: got %b want 01", {a_rvalid, a_ready}); end
    endtask

    task automatic test_store_half;
        drive(1'b1, 2'd1, 1'b0, 32'h2, 64'h1234);
        @(negedge clk);
        vec++; if (a_ben !== 4'b1100) begin errs++; $display("FAIL sh_ben: got %b want 1100", a_ben); end
        vec++; if (a_mwdata !== 32'h1234_1234) begin errs++; $display("FAIL sh_wdata: got %h want 12341234", a_mwdata); end
        @(negedge clk);
        vec++; if ({a_rvalid, a_cause} !== 3'b100) begin errs++; $display("FAIL sh_rsp: got %b want 100", {a_rvalid, a_cause}); end
        vec++; if (a_rdata !== 32'h0) begin errs++; $display("FAIL sh_rdata: got %h want 0", a_rdata); end
        @(negedge clk);
    endtask

    task automatic test_misalign;
        drive(1'b0, 2'd2, 1'b0, 32'h6, 64'h0);
        @(negedge clk);
        vec++; if ({a_rvalid, a_cause} !== 3'b101) begin errs++; $display("FAIL mis_rsp: got %b want 101", {a_rvalid, a_cause}); end
        vec++; if (a_cen !== 1'b0) begin errs++; $display("FAIL mis_cen: got %b want 0", a_cen); end
        @(negedge clk);
        vec++; if ({a_rvalid, a_cen} !== 2'b00) begin errs++; $display("FAIL mis_after: got %b want 00", {a_rvalid, a_cen}); end
    endtask

    task automatic test_stall;
        mem_rdata = 64'h0000_0000_1122_3344;
        mem_stall = 1'b1;
        drive(1'b0, 2'd2, 1'b0, 32'h10, 64'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vec++; if ({a_cen, a_rvalid, a_maddr} !== {2'b10, 32'h10}) begin errs++; $display("FAIL st_hold%0d: got %b/%b/%h want 1/0/10", i, a_cen, a_rvalid, a_maddr); end
            if (i == 3) mem_stall = 1'b0;
        end
        @(negedge clk);
        vec++; if ({a_rvalid, a_cause} !== 3'b100) begin errs++; $display("FAIL st_rsp: got %b want 100", {a_rvalid, a_cause}); end
        vec++; if (a_rdata !== 32'h1122_3344) begin errs++; $display("FAIL st_rdata: got %h want 11223344", a_rdata); end
    endtask

    task automatic test_bus_error;
        mem_rdata = 64'h0000_0000_DEAD_BEEF;
        mem_error = 1'b1;
        drive(1'b0, 2'd2, 1'b0, 32'h30, 64'h0);
        @(negedge clk);
        vec++; if (a_cen !== 1'b1) begin errs++; $display("FAIL be_cen: got %b want 1", a_cen); end
        @(negedge clk);
        vec++; if ({a_rvalid, a_cause} !== 3'b110) begin errs++; $display("FAIL be_rsp: got %b want 110", {a_rvalid, a_cause}); end
        vec++; if (a_rdata !== 32'h0) begin errs++; $display("FAIL be_rdata: got %h want 0", a_rdata); end
        mem_error = 1'b0;
    endtask

    task automatic test_timeout;
        mem_rdata = 64'h0000_0000_5555_AAAA;
        mem_stall = 1'b1;
        drive(1'b0, 2'd2, 1'b0, 32'h20, 64'h0);
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            vec++; if ({a_cen, a_rvalid} !== 2'b10) begin errs++; $display("FAIL to_hold%0d: got %b want 10", i, {a_cen, a_rvalid}); end
        end
        @(negedge clk);
        vec++; if ({a_rvalid, a_cause, a_cen} !== 4'b1110) begin errs++; $display("FAIL to_rsp: got %b want 1110", {a_rvalid, a_cause, a_cen}); end
        vec++; if (a_rdata !== 32'h0) begin errs++; $display("FAIL to_rdata: got %h want 0", a_rdata); end
        mem_stall = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_access;
        mem_stall = 1'b1;
        drive(1'b0, 2'd2, 1'b0, 32'h40, 64'h0);
        @(negedge clk);
        vec++; if (a_cen !== 1'b1) begin errs++; $display("FAIL rm_cen: got %b want 1", a_cen); end
        reset = 1'b1;
        @(negedge clk);
        vec++; if ({a_cen, a_ready, a_rvalid} !== 3'b010) begin errs++; $display("FAIL rm_idle: got %b want 010", {a_cen, a_ready, a_rvalid}); end
        reset = 1'b0;
        mem_stall = 1'b0;
        repeat (2) begin
            @(negedge clk);
            vec++; if (a_rvalid !== 1'b0) begin errs++; $display("FAIL rm_norsp: got %b want 0", a_rvalid); end
        end
    endtask

    task automatic test_xlen64;
        mem_rdata = 64'h8877_6655_4433_2211;
        drive(1'b0, 2'd3, 1'b0, 32'h8, 64'h0);
        @(negedge clk);
        vec++; if ({b_cen, b_ben, b_maddr} !== {1'b1, 8'h00, 32'h8}) begin errs++; $display("FAIL ld64_acc: got %b/%h/%h want 1/00/8", b_cen, b_ben, b_maddr); end
        vec++; if ({a_rvalid, a_cause, a_cen} !== 4'b1010) begin errs++; $display("FAIL ld64_x32mis: got %b want 1010", {a_rvalid, a_cause, a_cen}); end
        @(negedge clk);
        vec++; if ({b_rvalid, b_cause} !== 3'b100) begin errs++; $display("FAIL ld64_rsp: got %b want 100", {b_rvalid, b_cause}); end
        vec++; if (b_rdata !== 64'h8877_6655_4433_2211) begin errs++; $display("FAIL ld64_rdata: got %h want 8877665544332211", b_rdata); end
        mem_rdata = 64'hF00D_1234_5678_9ABC;
        drive(1'b0, 2'd1, 1'b0, 32'hE, 64'h0);
        @(negedge clk);
        vec++; if ({b_maddr, a_maddr} !== {32'h8, 32'hC}) begin errs++; $display("FAIL lh_addr: got %h/%h want 8/c", b_maddr, a_maddr); end
        @(negedge clk);
        vec++; if (b_rdata !== 64'h0000_0000_0000_F00D) begin errs++; $display("FAIL lhu64_rdata: got %h want f00d", b_rdata); end
        vec++; if (a_rdata !== 32'h0000_5678) begin errs++; $display("FAIL lhu32_rdata: got %h want 5678", a_rdata); end
        drive(1'b0, 2'd1, 1'b1, 32'hE, 64'h0);
        repeat (2) @(negedge clk);
        vec++; if (b_rdata !== 64'hFFFF_FFFF_FFFF_F00D) begin errs++; $display("FAIL lhs64_rdata: got %h want fffffffffffff00d", b_rdata); end
        drive(1'b1, 2'd2, 1'b0, 32'h4, 64'hCAFE_BABE);
        @(negedge clk);
        vec++; if (b_ben !== 8'hF0) begin errs++; $display("FAIL sw64_ben: got %h want f0", b_ben); end
        vec++; if (b_mwdata !== 64'hCAFE_BABE_CAFE_BABE) begin errs++; $display("FAIL sw64_wdata: got %h want cafebabecafebabe", b_mwdata); end
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_load_byte;
        test_store_half;
        test_misalign;
        test_stall;
        test_bus_error;
        test_timeout;
        test_reset_mid_access;
        test_xlen64;
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
